// File: rtl/sqrt_job_sequencer.sv
// sqrt_job_sequencer
//   Feeder for the iterative square-root core. Operands arrive on a valid/ready stream and are
//   buffered in a small FIFO. One job at a time is launched into the core through its start/ready
//   handshake. The 4-bit result is captured and presented together with its operand on a
//   single-slot valid/ready output. A watchdog abandons a job whose core never returns ready.
//
// Ports
//   i_clk            rising-edge clock, shared with the core
//   i_clear          synchronous active-high reset, also wired to the core's clear
//   i_in_valid       operand offered
//   o_in_ready       FIFO can accept (not full)
//   i_in_num[6:0]    operand
//   i_core_ready     core idle
//   i_core_result    core result, stable while i_core_ready=1
//   o_core_start     launch pulse to the core
//   o_core_num[6:0]  operand to the core, valid with o_core_start
//   o_out_valid      result available
//   i_out_ready      consumer accepts the result
//   o_out_num[6:0]   operand the result belongs to
//   o_out_result     square root, 0 when the job timed out
//   o_out_timeout    result was abandoned by the watchdog
//   o_busy           job in progress or operands queued
//   o_jobs_done[7:0] completed output handshakes, wraps at 256

module sqrt_job_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned AW      = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       i_clk,
  input  logic       i_clear,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [6:0] i_in_num,
  input  logic       i_core_ready,
  input  logic [3:0] i_core_result,
  output logic       o_core_start,
  output logic [6:0] o_core_num,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [6:0] o_out_num,
  output logic [3:0] o_out_result,
  output logic       o_out_timeout,
  output logic       o_busy,
  output logic [7:0] o_jobs_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [AW:0]   LP_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LP_CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] LP_PTR_ONE  = AW'(1);
  localparam logic [7:0]    LP_TMO_LAST = 8'(TIMEOUT - 1);

  // FIFO storage and pointers
  logic [6:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Job control
  logic [1:0] r_state;
  logic [7:0] r_timer;
  logic [6:0] r_job_num;

  // Output slot
  logic       r_out_valid;
  logic [6:0] r_out_num;
  logic [3:0] r_out_result;
  logic       r_out_timeout;
  logic [7:0] r_jobs_done;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_launch;

  // in_ready depends on occupancy only, so a pop in the same cycle never frees a full FIFO.
  assign w_full   = (r_count == LP_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_push   = i_in_valid & ~w_full;
  assign w_launch = (r_state == S_IDLE) & ~w_empty & i_core_ready;

  assign o_in_ready    = ~w_full;
  assign o_core_start  = w_launch;
  assign o_core_num    = r_mem[r_rd_ptr];
  assign o_out_valid   = r_out_valid;
  assign o_out_num     = r_out_num;
  assign o_out_result  = r_out_result;
  assign o_out_timeout = r_out_timeout;
  assign o_busy        = (r_state != S_IDLE) | ~w_empty;
  assign o_jobs_done   = r_jobs_done;

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_in_num;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_launch) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      case ({w_push, w_launch})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_job_num     <= '0;
      r_out_valid   <= 1'b0;
      r_out_num     <= '0;
      r_out_result  <= '0;
      r_out_timeout <= 1'b0;
      r_jobs_done   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_job_num <= r_mem[r_rd_ptr];
            r_state   <= S_LAUNCH;
          end
        end
        // Core spends this cycle loading the operand with core_ready low.
        S_LAUNCH: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + 8'd1;
          // A returning core wins over a watchdog expiry in the same cycle.
          if (i_core_ready) begin
            r_out_result  <= i_core_result;
            r_out_num     <= r_job_num;
            r_out_timeout <= 1'b0;
            r_out_valid   <= 1'b1;
            r_state       <= S_HOLD;
          end else if (r_timer == LP_TMO_LAST) begin
            r_out_result  <= '0;
            r_out_num     <= r_job_num;
            r_out_timeout <= 1'b1;
            r_out_valid   <= 1'b1;
            r_state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
            r_jobs_done <= r_jobs_done + 8'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_job_sequencer.sv
// Bench for sqrt_job_sequencer with a behavioural square-root core sharing clk and clear.
// Expected results are hand-computed constants queued at push time; a monitor pops and compares
// on every output handshake.

module tb_sqrt_job_sequencer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned AW      = 2;
  localparam int unsigned TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_num;
  logic       core_ready;
  logic [3:0] core_result;
  logic       core_start;
  logic [6:0] core_num;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_num;
  logic [3:0] out_result;
  logic       out_timeout;
  logic       busy;
  logic [7:0] jobs_done;

  always #5 clk = ~clk;

  sqrt_job_sequencer #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_clear      (clear),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_num     (in_num),
    .i_core_ready (core_ready),
    .i_core_result(core_result),
    .o_core_start (core_start),
    .o_core_num   (core_num),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_num    (out_num),
    .o_out_result (out_result),
    .o_out_timeout(out_timeout),
    .o_busy       (busy),
    .o_jobs_done  (jobs_done)
  );

  // ---------------- behavioural sqrt core ----------------
  int unsigned core_lat  = 3;
  logic        core_hang = 1'b0;
  logic [7:0]  core_cnt;
  logic [3:0]  core_res;

  function automatic logic [3:0] isqrt7(input logic [6:0] n);
    int r = 0;
    for (int k = 0; k < 12; k++) if (k * k <= int'(n)) r = k;
    return 4'(r);
  endfunction

  assign core_ready  = (core_cnt == 8'd0);
  assign core_result = core_res;

  always @(posedge clk) begin
    if (clear) begin
      core_cnt <= 8'd0;
      core_res <= 4'd0;
    end else if (core_start && core_ready) begin
      core_cnt <= 8'(core_lat);
      core_res <= isqrt7(core_num);
    end else if (core_cnt != 8'd0 && !core_hang) begin
      core_cnt <= core_cnt - 8'd1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [6:0] num;
    logic [3:0] res;
    logic       tmo;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks  = 0;
  int unsigned n_errors  = 0;
  int unsigned cycle     = 0;
  int unsigned start_cnt = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!clear) begin
      if (core_start) begin
        start_cnt++;
        check("start_needs_core_ready", 32'(core_ready), 1);
        check("start_while_holding", 32'(out_valid), 0);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got num=%0d result=%0d, expected no output",
                   out_num, out_result);
        end else begin
          e = sb_q.pop_front();
          check("out_num", 32'(out_num), 32'(e.num));
          check("out_result", 32'(out_result), 32'(e.res));
          check("out_timeout", 32'(out_timeout), 32'(e.tmo));
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic try_push(input logic [6:0] num, input logic [3:0] res, input logic tmo,
                          input int max_cyc, output bit ok);
    exp_t e;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_num   = num;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok    = 1'b1;
        e.num = num;
        e.res = res;
        e.tmo = tmo;
        sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic push(input string name, input logic [6:0] num, input logic [3:0] res,
                      input int max_cyc);
    bit ok;
    try_push(num, res, 1'b0, max_cyc, ok);
    check({name, "_accepted"}, 32'(ok), 1);
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (!busy && !out_valid && sb_q.size() == 0) done = 1'b1;
    end
    check({name, "_drained"}, 32'(done), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check({name, "_out_valid"}, 32'(seen), 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          ok;
    bit          seen;
    int unsigned s0;
    int unsigned t_start;
    int unsigned t_out;

    clear     = 1'b1;
    in_valid  = 1'b0;
    in_num    = 7'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 clear = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_core_start", 32'(core_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_jobs_done", 32'(jobs_done), 0);
    check("rst_out_fields", {21'd0, out_num, out_result, out_timeout}, 0);
    @(posedge clk);
    #1;

    // 1: single job, launch one cycle after the push
    push("t1_push49", 7'd49, 4'd7, 1);
    @(negedge clk);
    check("t1_start_latency", 32'(core_start), 1);
    @(posedge clk);
    #1;
    wait_idle("t1", 100);
    check("t1_jobs_done", 32'(jobs_done), 1);

    // 2: back-to-back pushes, results in order, one launch per job
    s0 = start_cnt;
    push("t2_push16", 7'd16, 4'd4, 1);
    push("t2_push100", 7'd100, 4'd10, 1);
    push("t2_push1", 7'd1, 4'd1, 1);
    push("t2_push36", 7'd36, 4'd6, 1);
    wait_idle("t2", 200);
    check("t2_start_count", start_cnt - s0, 4);
    check("t2_jobs_done", 32'(jobs_done), 5);

    // 3: stalled consumer back-pressures the FIFO
    out_ready = 1'b0;
    push("t3_push9", 7'd9, 4'd3, 1);
    push("t3_push25", 7'd25, 4'd5, 1);
    push("t3_push4", 7'd4, 4'd2, 1);
    push("t3_push64", 7'd64, 4'd8, 1);
    push("t3_push81", 7'd81, 4'd9, 1);
    try_push(7'd121, 4'd11, 1'b0, 30, ok);
    check("t3_sixth_rejected", 32'(ok), 0);
    @(negedge clk);
    check("t3_in_ready_low", 32'(in_ready), 0);
    check("t3_holding", 32'(out_valid), 1);
    check("t3_jobs_done_stalled", 32'(jobs_done), 5);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push("t3_push121", 7'd121, 4'd11, 200);
    wait_idle("t3", 300);
    check("t3_jobs_done", 32'(jobs_done), 11);

    // 4: hung core, watchdog fires TIMEOUT+2 cycles after the launch cycle
    core_hang = 1'b1;
    try_push(7'd50, 4'd0, 1'b1, 1, ok);
    check("t4_push50_accepted", 32'(ok), 1);
    seen = 1'b0;
    t_start = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (core_start) begin
        seen = 1'b1;
        t_start = cycle;
      end
    end
    check("t4_launch_seen", 32'(seen), 1);
    seen = 1'b0;
    t_out = 0;
    for (int i = 0; i < int'(TIMEOUT) + 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        t_out = cycle;
      end
    end
    check("t4_timeout_seen", 32'(seen), 1);
    check("t4_timeout_delay", t_out - t_start, TIMEOUT + 2);
    @(posedge clk);
    #1;
    core_hang = 1'b0;
    push("t4_push2", 7'd2, 4'd1, 20);
    wait_idle("t4", 200);
    check("t4_jobs_done", 32'(jobs_done), 13);

    // 5: clear in WAIT with three queued drops everything silently
    core_lat = 20;
    push("t5_push10", 7'd10, 4'd3, 1);
    push("t5_push81", 7'd81, 4'd9, 1);
    push("t5_push49", 7'd49, 4'd7, 1);
    push("t5_push16", 7'd16, 4'd4, 1);
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("t5_busy", 32'(busy), 0);
    check("t5_in_ready", 32'(in_ready), 1);
    check("t5_jobs_done", 32'(jobs_done), 0);
    check("t5_out_valid", 32'(out_valid), 0);
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;
    core_lat = 3;
    push("t5_push25", 7'd25, 4'd5, 1);
    wait_idle("t5", 100);
    check("t5_jobs_done_after", 32'(jobs_done), 1);

    // 6: push and pop in one cycle at count=2, ordering across pointer wrap
    out_ready = 1'b0;
    push("t6_pushA", 7'd100, 4'd10, 1);
    wait_valid("t6_A_hold", 50);
    push("t6_pushB", 7'd121, 4'd11, 1);
    push("t6_pushC", 7'd64, 4'd8, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    try_push(7'd36, 4'd6, 1'b0, 1, ok);
    check("t6_pushD_with_pop", 32'(ok), 1);
    wait_valid("t6_B_hold", 50);
    try_push(7'd9, 4'd3, 1'b0, 1, ok);
    check("t6_pushE", 32'(ok), 1);
    try_push(7'd4, 4'd2, 1'b0, 1, ok);
    check("t6_pushF", 32'(ok), 1);
    try_push(7'd1, 4'd1, 1'b0, 5, ok);
    check("t6_full_after_two_more", 32'(ok), 0);
    out_ready = 1'b1;
    push("t6_pushG", 7'd1, 4'd1, 200);
    push("t6_pushH", 7'd16, 4'd4, 200);
    push("t6_pushI", 7'd49, 4'd7, 200);
    push("t6_pushJ", 7'd81, 4'd9, 200);
    wait_idle("t6", 300);
    check("t6_jobs_done", 32'(jobs_done), 11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
